mux4_rr_arbiter: RTL

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

---
 rtl/mux4_rr_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter over four requesters feeding a registered 4x1 2-bit mux.
// Grants are held for at most MAX_HOLD cycles; release and re-arbitration share one edge.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [3:0] Req,
  input  logic [1:0] A,
  input  logic [1:0] B,
  input  logic [1:0] C,
  input  logic [1:0] D,
  output logic [3:0] Gnt,
  output logic       S1,
  output logic       S0,
  output logic [1:0] Out,
  output logic       Valid
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0] state;
  logic [1:0] ptr;
  logic [3:0] cnt;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic [1:0] out;
  logic       valid;

  logic       rel;
  logic [1:0] base_ptr;
  logic [2:0] arb;
  logic [1:0] mux_data;

  // Returns {found, index} of the first set request scanning upward from p.
  function automatic logic [2:0] arbitrate(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = p + 2'(i);
      if (!res[2] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    rel      = (state == BUSY) && (!Req[sel] || (cnt == 4'(MAX_HOLD)));
    // On release the pointer advance is visible to the same-edge arbitration.
    base_ptr = rel ? (sel + 2'd1) : ptr;
    arb      = arbitrate(Req, base_ptr);
  end

  always_comb begin
    mux_data = '0;
    case (sel)
      2'd0: mux_data = A;
      2'd1: mux_data = B;
      2'd2: mux_data = C;
      2'd3: mux_data = D;
      default: mux_data = '0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
      sel   <= '0;
      gnt   <= '0;
      out   <= '0;
      valid <= 1'b0;
    end else begin
      valid <= (state == BUSY);
      if (state == BUSY) out <= mux_data;

      case (state)
        IDLE: begin
          if (arb[2]) begin
            gnt   <= 4'b0001 << arb[1:0];
            sel   <= arb[1:0];
            cnt   <= 4'd1;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (rel) begin
            ptr <= sel + 2'd1;
            if (arb[2]) begin
              gnt <= 4'b0001 << arb[1:0];
              sel <= arb[1:0];
              cnt <= 4'd1;
            end else begin
              gnt   <= '0;
              cnt   <= '0;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Gnt   = gnt;
  assign S1    = sel[1];
  assign S0    = sel[0];
  assign Out   = out;
  assign Valid = valid;

endmodule
